// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: single-cycle ops plus an iterative shift-add unsigned MUL.
// Results and flags are registered; busy/done let the control FSM stall on MUL.
module alu_exec_stage #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ALU_1_IN,
  input  logic [WIDTH-1:0] ALU_2_IN,
  input  logic [3:0]       C_ALUOp,
  input  logic             C_ALUStart,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] ALU_Hi,
  output logic             ALU_Zero,
  output logic             ALU_Ovf,
  output logic             ALU_Busy,
  output logic             ALU_Done
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MUL_RUN = 1'b1;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SLL   = 4'b0110;
  localparam logic [3:0] OP_SRL   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_PASSB = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;

  logic [SHAMT_W-1:0]      shamt;
  logic [WIDTH-1:0]        sum_w, diff_w, res;
  logic signed [WIDTH-1:0] a_sgn;
  logic                    res_ovf;
  logic [WIDTH:0]          part;
  logic [2*WIDTH-1:0]      acc_step;

  assign shamt = ALU_2_IN[SHAMT_W-1:0];
  assign sum_w = ALU_1_IN + ALU_2_IN;
  assign diff_w = ALU_1_IN - ALU_2_IN;
  assign a_sgn = $signed(ALU_1_IN);

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (C_ALUOp)
      OP_ADD: begin
        res     = sum_w;
        res_ovf = (ALU_1_IN[WIDTH-1] == ALU_2_IN[WIDTH-1]) &&
                  (sum_w[WIDTH-1] != ALU_1_IN[WIDTH-1]);
      end
      OP_SUB: begin
        res     = diff_w;
        res_ovf = (ALU_1_IN[WIDTH-1] != ALU_2_IN[WIDTH-1]) &&
                  (diff_w[WIDTH-1] != ALU_1_IN[WIDTH-1]);
      end
      OP_AND:   res = ALU_1_IN & ALU_2_IN;
      OP_OR:    res = ALU_1_IN | ALU_2_IN;
      OP_XOR:   res = ALU_1_IN ^ ALU_2_IN;
      OP_NOR:   res = ~(ALU_1_IN | ALU_2_IN);
      OP_SLL:   res = ALU_1_IN << shamt;
      OP_SRL:   res = ALU_1_IN >> shamt;
      OP_SRA:   res = $unsigned(a_sgn >>> shamt);
      OP_SLT:   res = {{(WIDTH-1){1'b0}},
                       $signed(ALU_1_IN) < $signed(ALU_2_IN)};
      OP_PASSB: res = ALU_2_IN;
      default:  res = '0;
    endcase
  end

  // Multiplier sits in the low half of acc and is consumed LSB first.
  always_comb begin
    part = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
           {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
    acc_step = {part, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    a_d     = a_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (C_ALUStart) begin
          if (C_ALUOp == OP_MUL) begin
            a_d     = ALU_1_IN;
            acc_d   = {{WIDTH{1'b0}}, ALU_2_IN};
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = MUL_RUN;
          end else begin
            out_d  = res;
            hi_d   = '0;
            zero_d = (res == '0);
            ovf_d  = res_ovf;
            done_d = 1'b1;
          end
        end
      end
      default: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHAMT_W'(WIDTH-1)) begin
          out_d   = acc_step[WIDTH-1:0];
          hi_d    = acc_step[2*WIDTH-1:WIDTH];
          zero_d  = (acc_step[WIDTH-1:0] == '0);
          ovf_d   = (acc_step[2*WIDTH-1:WIDTH] != '0);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ALU_Out  = out_q;
  assign ALU_Hi   = hi_q;
  assign ALU_Zero = zero_q;
  assign ALU_Ovf  = ovf_q;
  assign ALU_Busy = busy_q;
  assign ALU_Done = done_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: vector table for single-cycle ops,
// hand-written sequences for MUL timing, ignored starts, reset and back-to-back.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic [3:0]  op;
  logic        start;
  logic [15:0] out, hi;
  logic        zero, ovf, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ALU_1_IN   (a),
    .ALU_2_IN   (b),
    .C_ALUOp    (op),
    .C_ALUStart (start),
    .ALU_Out    (out),
    .ALU_Hi     (hi),
    .ALU_Zero   (zero),
    .ALU_Ovf    (ovf),
    .ALU_Busy   (busy),
    .ALU_Done   (done)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Outputs are checked at the falling edge, inputs change there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_res(input string name, input logic [15:0] e_out,
                         input logic [15:0] e_hi, input logic e_zero,
                         input logic e_ovf);
    chk({name, ".done"}, 32'(done), 32'd1);
    chk({name, ".out"},  32'(out),  32'(e_out));
    chk({name, ".hi"},   32'(hi),   32'(e_hi));
    chk({name, ".zero"}, 32'(zero), 32'(e_zero));
    chk({name, ".ovf"},  32'(ovf),  32'(e_ovf));
  endtask

  task automatic issue(input logic [3:0] o, input logic [15:0] x,
                       input logic [15:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int ndone;
    vecs[0]  = '{"add_ovf",  4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[1]  = '{"sub_zero", 4'b0001, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{"and",      4'b0010, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0};
    vecs[3]  = '{"or",       4'b0011, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0};
    vecs[4]  = '{"xor",      4'b0100, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0};
    vecs[5]  = '{"nor",      4'b0101, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0};
    vecs[6]  = '{"sll",      4'b0110, 16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0};
    vecs[7]  = '{"sra",      4'b1000, 16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0};
    vecs[8]  = '{"srl",      4'b0111, 16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0};
    vecs[9]  = '{"slt_t",    4'b1001, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0};
    vecs[10] = '{"slt_f",    4'b1001, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{"passb",    4'b1010, 16'h1234, 16'hABCD, 16'hABCD, 1'b0, 1'b0};
    vecs[12] = '{"op_c",     4'b1100, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
    vecs[13] = '{"sub_ovf",  4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    vecs[14] = '{"add_wrap", 4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[15] = '{"sra_pos",  4'b1000, 16'h7000, 16'h000F, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; a = '0; b = '0; op = '0; start = 1'b0;
    @(negedge clk);
    tick();
    chk("rst.out",  32'(out),  32'd0);
    chk("rst.hi",   32'(hi),   32'd0);
    chk("rst.flag", 32'({zero, ovf, busy, done}), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk_res(vecs[i].name, vecs[i].out, 16'h0000, vecs[i].zero, vecs[i].ovf);
      tick();
      chk({vecs[i].name, ".done_low"}, 32'(done), 32'd0);
      chk({vecs[i].name, ".hold"}, 32'(out), 32'(vecs[i].out));
    end

    issue(4'b1011, 16'h0100, 16'h0100);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("mul.busy%0d", k), 32'({busy, done}), 32'b10);
      tick();
    end
    chk_res("mul", 16'h0000, 16'h0001, 1'b1, 1'b1);
    chk("mul.busy_end", 32'(busy), 32'd0);

    issue(4'b0011, 16'h0001, 16'h0002);
    chk_res("after_mul_or", 16'h0003, 16'h0000, 1'b0, 1'b0);

    op = 4'b1011; a = 16'h00FF; b = 16'h0003; start = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("ign.busy%0d", k), 32'({busy, done}), 32'b10);
      op = 4'(k % 4); a = 16'($urandom); b = 16'($urandom);
      tick();
    end
    start = 1'b0;
    chk_res("mul_ign", 16'h02FD, 16'h0000, 1'b0, 1'b0);
    tick();
    chk("ign.no_queue", 32'({busy, done}), 32'd0);

    op = 4'b0011; a = 16'h00F0; b = 16'h000F; start = 1'b1;
    tick();
    chk_res("b2b_or", 16'h00FF, 16'h0000, 1'b0, 1'b0);
    op = 4'b0100; a = 16'hAAAA; b = 16'hFFFF;
    tick();
    chk_res("b2b_xor", 16'h5555, 16'h0000, 1'b0, 1'b0);
    op = 4'b1010; a = 16'h0000; b = 16'h0000;
    tick();
    chk_res("b2b_passb", 16'h0000, 16'h0000, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    chk("b2b.end", 32'(done), 32'd0);

    issue(4'b0001, 16'h0009, 16'h0002);
    chk_res("pre_rst", 16'h0007, 16'h0000, 1'b0, 1'b0);
    issue(4'b1011, 16'h0100, 16'h0100);
    tick(); tick(); tick();
    rst = 1'b1;
    tick(); tick();
    chk("mrst.out",  32'(out),  32'd0);
    chk("mrst.hi",   32'(hi),   32'd0);
    chk("mrst.flag", 32'({zero, ovf, busy, done}), 32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done || busy) ndone++;
      tick();
    end
    chk("mrst.no_done", 32'(ndone), 32'd0);
    issue(4'b0000, 16'h0001, 16'h0001);
    chk_res("mrst.add", 16'h0002, 16'h0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
